// File: rtl/bit_deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package bit_deser_pkg;

  // EMPTY: no bits collected; FILL: collecting; STALL: last slot pending
  // behind an occupied output register.
  typedef enum logic [1:0] {EMPTY, FILL, STALL} deser_state_t;

  localparam int DROP_W   = 8;
  localparam int DROP_MAX = 255;

endpackage

// File: rtl/deser_hold_reg.sv
// One-entry output register with valid/ready. A load and a drain on the same
// edge keep valid high with the newly loaded word. Data is held (not cleared)
// after it is consumed.
module deser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Next word/valid: a load wins over a drain in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && drain) begin
      valid_d = 1'b0;
    end
  end

  // Output register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel stage: packs accepted bits into WIDTH-bit words, hands
// them to a one-entry output register, realigns on frame_sync and counts
// discarded partial words with a saturating counter.
module bit_deserializer
  import bit_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              frame_sync,
  output logic [WIDTH-1:0]  word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_W'(DROP_MAX)) ? v : v + 1'b1;
  endfunction

  // One-hot placement of a bit at its word position for bit index idx.
  function automatic logic [WIDTH-1:0] place_bit(input logic [CNT_W-1:0] idx,
                                                 input logic b);
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] pos;
    pos      = (MSB_FIRST != 0) ? (LAST - idx) : idx;
    res      = '0;
    res[pos] = b;
    return res;
  endfunction

  deser_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              bit_acc;
  logic              load;
  logic [WIDTH-1:0]  load_word;
  logic              wv_next;

  // Only the final slot can stall, and only when the output is full and not
  // draining this very cycle.
  assign bit_ready = rst & ~((state_q == STALL) & ~word_ready);
  assign bit_acc   = bit_valid & bit_ready;
  assign wv_next   = load | (word_valid & ~word_ready);

  // Shift register, bit index and drop counter update; frame_sync has priority
  // and turns a same-cycle bit into index 0 of the new word.
  always_comb begin
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    drop_d    = drop_q;
    load      = 1'b0;
    load_word = sh_q;
    if (frame_sync) begin
      cnt_d = '0;
      sh_d  = '0;
      if (cnt_q != '0) drop_d = sat_inc(drop_q);
      if (bit_acc) begin
        sh_d  = place_bit('0, bit_in);
        cnt_d = CNT_W'(1);
      end
    end else if (bit_acc) begin
      if (cnt_q == LAST) begin
        load      = 1'b1;
        load_word = sh_q | place_bit(cnt_q, bit_in);
        cnt_d     = '0;
        sh_d      = '0;
      end else begin
        sh_d  = sh_q | place_bit(cnt_q, bit_in);
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Next FSM state follows the upcoming bit index and output occupancy.
  always_comb begin
    state_d = FILL;
    if (cnt_d == '0)                     state_d = EMPTY;
    else if ((cnt_d == LAST) && wv_next) state_d = STALL;
  end

  // Control and datapath state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      sh_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      drop_q  <= drop_d;
    end
  end

  deser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_word),
    .drain     (word_ready),
    .data      (word_out),
    .valid     (word_valid)
  );

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: an MSB-first and an LSB-first instance share
// the same stimulus and are compared against a bit-queue reference model.
module tb_bit_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         bit_in, bit_valid, frame_sync, word_ready;
  logic         bit_ready, word_valid, bit_ready_l, word_valid_l;
  logic [W-1:0] word_out, word_out_l;
  logic [7:0]   drop_cnt, drop_cnt_l;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: bits of the word in progress, output slot, drop count.
  bit         part[$];
  logic       m_wv;
  logic [7:0] m_word, m_word_l;
  int         m_drop;
  logic       m_rdy;
  logic       rdy_seen;
  logic [7:0] rx[$];

  bit_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .frame_sync(frame_sync), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .drop_cnt(drop_cnt)
  );

  bit_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_l), .frame_sync(frame_sync), .word_out(word_out_l),
    .word_valid(word_valid_l), .word_ready(word_ready), .drop_cnt(drop_cnt_l)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pack_msb();
    int v = 0;
    foreach (part[i]) v = v * 2 + int'(part[i]);
    return 8'(v);
  endfunction

  function automatic logic [7:0] pack_lsb();
    int v = 0;
    foreach (part[i]) v = v + (int'(part[i]) << i);
    return 8'(v);
  endfunction

  task automatic model_reset();
    part.delete();
    m_wv     = 1'b0;
    m_word   = '0;
    m_word_l = '0;
    m_drop   = 0;
  endtask

  // One clock: drive at the falling edge, note ready, advance the model,
  // then settle just after the rising edge.
  task automatic tick(input logic b, input logic v, input logic fs, input logic wr);
    logic acc, loaded, drained;
    @(negedge clk);
    bit_in = b; bit_valid = v; frame_sync = fs; word_ready = wr;
    #1;
    m_rdy    = !((part.size() == W - 1) && m_wv && !wr);
    rdy_seen = bit_ready;
    if (word_valid === 1'b1 && wr) rx.push_back(word_out);
    acc     = v && m_rdy;
    loaded  = 1'b0;
    drained = m_wv && wr;
    if (fs) begin
      if (part.size() != 0) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
      part.delete();
      if (acc) part.push_back(b);
    end else if (acc) begin
      part.push_back(b);
      if (part.size() == W) begin
        m_word   = pack_msb();
        m_word_l = pack_lsb();
        m_wv     = 1'b1;
        loaded   = 1'b1;
        part.delete();
      end
    end
    if (drained && !loaded) m_wv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] val, input logic wr);
    for (int i = 7; i >= 0; i--) tick(val[i], 1'b1, 1'b0, wr);
  endtask

  task automatic test_reset();
    rst = 1'b0; bit_in = 0; bit_valid = 0; frame_sync = 0; word_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (word_out !== 8'h00) $display("FAIL rst_word_out: got %h want 00", word_out); else pass_cnt++;
    total_cnt++;
    if (word_valid !== 1'b0) $display("FAIL rst_word_valid: got %b want 0", word_valid); else pass_cnt++;
    total_cnt++;
    if (bit_ready !== 1'b0) $display("FAIL rst_bit_ready: got %b want 0", bit_ready); else pass_cnt++;
    total_cnt++;
    if (drop_cnt !== 8'd0) $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bit_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bit_ready); else pass_cnt++;
  endtask

  task automatic test_a5();
    send_byte(8'hA5, 1'b1);
    total_cnt++;
    if (word_out !== 8'hA5) $display("FAIL a5_word: got %h want a5", word_out); else pass_cnt++;
    total_cnt++;
    if (word_valid !== 1'b1) $display("FAIL a5_valid: got %b want 1", word_valid); else pass_cnt++;
    total_cnt++;
    if (drop_cnt !== 8'd0) $display("FAIL a5_drop: got %0d want 0", drop_cnt); else pass_cnt++;
    total_cnt++;
    if (word_out_l !== m_word_l) $display("FAIL a5_lsb_word: got %h want %h", word_out_l, m_word_l); else pass_cnt++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (word_valid !== 1'b0) $display("FAIL a5_one_cycle: got %b want 0", word_valid); else pass_cnt++;
    total_cnt++;
    if (word_out !== 8'hA5) $display("FAIL a5_hold: got %h want a5", word_out); else pass_cnt++;
  endtask

  task automatic test_bit_order();
    send_byte(8'hC0, 1'b1);
    total_cnt++;
    if (word_out !== 8'hC0) $display("FAIL order_msb: got %h want c0", word_out); else pass_cnt++;
    total_cnt++;
    if (word_out_l !== 8'h03) $display("FAIL order_lsb: got %h want 03", word_out_l); else pass_cnt++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] b2;
    rx.delete();
    b2 = 8'h3C;
    send_byte(8'hA5, 1'b0);
    for (int i = 7; i >= 1; i--) tick(b2[i], 1'b1, 1'b0, 1'b0);
    repeat (2) begin
      tick(b2[0], 1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (rdy_seen !== 1'b0) $display("FAIL stall_ready: got %b want 0", rdy_seen); else pass_cnt++;
    end
    total_cnt++;
    if (word_out !== 8'hA5) $display("FAIL stall_hold: got %h want a5", word_out); else pass_cnt++;
    tick(b2[0], 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (rdy_seen !== 1'b1) $display("FAIL drain_ready: got %b want 1", rdy_seen); else pass_cnt++;
    total_cnt++;
    if (word_out !== 8'h3C || word_valid !== 1'b1)
      $display("FAIL drain_load: got %h/%b want 3c/1", word_out, word_valid);
    else pass_cnt++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (rx.size() != 2) $display("FAIL stall_count: got %0d want 2", rx.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (rx[0] !== 8'hA5 || rx[1] !== 8'h3C)
        $display("FAIL stall_order: got %h %h want a5 3c", rx[0], rx[1]);
      else pass_cnt++;
    end
    total_cnt++;
    if (word_valid !== 1'b0) $display("FAIL stall_empty: got %b want 0", word_valid); else pass_cnt++;
  endtask

  task automatic test_frame_sync();
    logic [6:0] tail;
    tail = 7'b0100101;
    repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) tick(tail[i], 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (drop_cnt !== 8'd1) $display("FAIL sync_drop: got %0d want 1", drop_cnt); else pass_cnt++;
    total_cnt++;
    if (word_out !== 8'hA5 || word_valid !== 1'b1)
      $display("FAIL sync_word: got %h/%b want a5/1", word_out, word_valid);
    else pass_cnt++;
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (drop_cnt !== 8'd1) $display("FAIL sync_idle_drop: got %0d want 1", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b0; bit_valid = 1'b0; frame_sync = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (word_out !== 8'h00) $display("FAIL mrst_word: got %h want 00", word_out); else pass_cnt++;
    total_cnt++;
    if (word_valid !== 1'b0) $display("FAIL mrst_valid: got %b want 0", word_valid); else pass_cnt++;
    total_cnt++;
    if (bit_ready !== 1'b0) $display("FAIL mrst_ready: got %b want 0", bit_ready); else pass_cnt++;
    total_cnt++;
    if (drop_cnt !== 8'd0) $display("FAIL mrst_drop: got %0d want 0", drop_cnt); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h5A, 1'b1);
    total_cnt++;
    if (word_out !== 8'h5A || drop_cnt !== 8'd0)
      $display("FAIL mrst_after: got %h/%0d want 5a/0", word_out, drop_cnt);
    else pass_cnt++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 260; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      if (i == 254) begin
        total_cnt++;
        if (drop_cnt !== 8'd255) $display("FAIL sat_reach: got %0d want 255", drop_cnt); else pass_cnt++;
      end
    end
    total_cnt++;
    if (drop_cnt !== 8'd255) $display("FAIL sat_nowrap: got %0d want 255", drop_cnt); else pass_cnt++;
    total_cnt++;
    if (drop_cnt_l !== 8'(m_drop)) $display("FAIL sat_lsb: got %0d want %0d", drop_cnt_l, m_drop); else pass_cnt++;
  endtask

  task automatic test_random();
    rst = 1'b0; bit_valid = 1'b0; frame_sync = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      tick(1'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0),
           1'($urandom));
      total_cnt++;
      if (rdy_seen !== m_rdy || bit_ready_l !== word_ready || 1'b1 === 1'b0) begin end
      if (rdy_seen !== m_rdy) $display("FAIL rnd_ready[%0d]: got %b want %b", n, rdy_seen, m_rdy); else pass_cnt++;
      total_cnt++;
      if (word_valid !== m_wv || word_valid_l !== m_wv)
        $display("FAIL rnd_valid[%0d]: got %b/%b want %b", n, word_valid, word_valid_l, m_wv);
      else pass_cnt++;
      total_cnt++;
      if (word_out !== m_word) $display("FAIL rnd_word[%0d]: got %h want %h", n, word_out, m_word); else pass_cnt++;
      total_cnt++;
      if (word_out_l !== m_word_l) $display("FAIL rnd_word_lsb[%0d]: got %h want %h", n, word_out_l, m_word_l); else pass_cnt++;
      total_cnt++;
      if (drop_cnt !== 8'(m_drop) || drop_cnt_l !== 8'(m_drop))
        $display("FAIL rnd_drop[%0d]: got %0d/%0d want %0d", n, drop_cnt, drop_cnt_l, m_drop);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_bit_order();
    test_back_to_back_stall();
    test_frame_sync();
    test_mid_reset();
    test_drop_saturate();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bit_deserializer.md
# bit_deserializer

Serial-to-parallel stage consuming the single-bit registered stream produced by the D flip-flop stage (its `q`) and packing it into WIDTH-bit words. Bits arrive under a valid/ready handshake. Completed words are presented on a one-entry output register with its own valid/ready handshake. A frame-sync input realigns word boundaries, and a saturating counter records discarded partial words.

## Interface
- WIDTH, 8, bits per output word (≥2)
- MSB_FIRST, 1, 1: first accepted bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0]
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = in reset)
- bit_in  in  1  serial data bit (driven from upstream flip-flop q)
- bit_valid  in  1  bit_in is valid this cycle
- bit_ready  out  1  stage can accept a bit this cycle
- frame_sync  in  1  synchronous word-boundary realign
- word_out  out  WIDTH  assembled word
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  downstream accepts word_out this cycle
- drop_cnt  out  8  count of partial words discarded by frame_sync, saturates at 255

## Operation
- Bit accept: bit_valid & bit_ready at a rising edge. Word accept: word_valid & word_ready.
- Internal: shift register sh[WIDTH-1:0], bit index cnt (0..WIDTH-1), output register, drop_cnt.
- FSM states: EMPTY (cnt=0), FILL (0<cnt<WIDTH-1 or cnt=WIDTH-1 with output free), STALL (cnt=WIDTH-1, word_valid=1, word_ready=0).
- bit_ready = rst & !(cnt==WIDTH-1 & word_valid & !word_ready). This is combinational from word_ready, so a same-cycle drain allows the final bit through.
- Accepted bit at index cnt goes to position WIDTH-1-cnt (MSB_FIRST=1) or position cnt (MSB_FIRST=0). cnt then increments.
- Accept at cnt==WIDTH-1: the full word, including the current bit, loads into word_out. word_valid is set, cnt wraps to 0, sh clears.
- word_valid clears on word accept unless a new word loads in the same edge; in that case it stays 1 with the new word.
- word_out holds its value while word_valid=0 (no clearing on accept).
- frame_sync=1 at an edge:
  - cnt and sh clear.
  - If cnt≠0 before the edge, drop_cnt increments (saturating at 255). With cnt=0 there is no increment.
  - If a bit is accepted in the same cycle, that bit becomes index 0 of the new word (cnt becomes 1).
  - frame_sync never affects word_out or word_valid.
- Reset (rst=0), asynchronous and immediate: cnt=0, sh=0, word_out=0, word_valid=0, drop_cnt=0, bit_ready=0, FSM=EMPTY. A partial word is lost without a drop_cnt increment.

## Timing
- Latency: final bit accepted at edge N → word_valid=1 and word_out valid from just after edge N.
- Throughput: one bit per cycle sustained while word_ready=1. There are no bubbles at word boundaries.
- Only bit_ready has a combinational input path (from word_ready, rst). All other outputs are registered.
- The first bit can be accepted at the first rising edge after rst deasserts.

## Structure
- Package bit_deser_pkg: typedef enum {EMPTY, FILL, STALL} deser_state_t; localparam DROP_W=8; localparam DROP_MAX=255.
- One sub-module, deser_hold_reg: WIDTH-bit output register with valid/ready, load/drain-same-cycle handling and async active-low reset. The top holds the FSM, shift register, cnt and drop_cnt.
- Reuse the existing interface/test/driver/monitor/scoreboard bench layout. The scoreboard models word packing and drop_cnt.

## Test plan
- WIDTH=8, MSB_FIRST=1, word_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles → word_out=0xA5, word_valid=1 for exactly one cycle after the 8th edge; drop_cnt=0.
- Bits 1,1,0,0,0,0,0,0 → 0xC0 with MSB_FIRST=1; 0x03 with MSB_FIRST=0.
- word_ready=0, stream 0xA5 then 0x3C → bit_ready=0 while the 8th bit of 0x3C waits. Raise word_ready for 2 cycles → 0xA5 then 0x3C in order, no bit lost or duplicated.
- 3 bits sent, then frame_sync=1 with bit_valid=1 carrying bit 1, then 7 more bits 0,1,0,0,1,0,1 → drop_cnt=1, word_out=0xA5.
- 5 bits sent, rst=0 between edges → word_out=0, word_valid=0, bit_ready=0, drop_cnt=0 immediately. After release, 8 bits of 0x5A → word_out=0x5A.
- 260 repetitions of (1 bit, then frame_sync) → drop_cnt=255, no wrap.
